// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: field widths, comparator op encoding, canonical NaN
// and helper functions used by the compare datapath and its controllers.
package fp32_pkg;

  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    CMP_GTE = 3'd0,
    CMP_GT  = 3'd1,
    CMP_EQ  = 3'd2,
    CMP_LT  = 3'd3,
    CMP_LTE = 3'd4
  } cmp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } argext_state_e;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[FP_MANT_W +: FP_EXP_W] == 8'hFF) && (x[FP_MANT_W-1:0] != 23'd0);
  endfunction

  // Maps sign-magnitude FP32 onto an unsigned key with the same total order
  // (-0.0 sorts just below +0.0, infinities at the ends).
  function automatic logic [31:0] order_key(input logic [31:0] x);
    if (x[31]) begin
      return ~x;
    end else begin
      return {1'b1, x[30:0]};
    end
  endfunction

endpackage

// File: rtl/fp32_cmp_core.sv
// Two-stage FP32 comparator: inputs registered, result computed and registered.
// NaN operands make every relation false and raise o_nan_err with the result.
module fp32_cmp_core
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_valid,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  cmp_op_e     i_op,
  output logic        o_res_valid,
  output logic        o_res,
  output logic        o_nan_err
);

  logic        v1_r;
  logic [31:0] a1_r;
  logic [31:0] b1_r;
  cmp_op_e     op1_r;
  logic [31:0] ka_s;
  logic [31:0] kb_s;
  logic        rel_s;
  logic        nan_s;

  // Stage 1: capture operands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_r  <= 1'b0;
      a1_r  <= 32'd0;
      b1_r  <= 32'd0;
      op1_r <= CMP_GTE;
    end else begin
      v1_r  <= i_valid;
      a1_r  <= i_a;
      b1_r  <= i_b;
      op1_r <= i_op;
    end
  end

  // Relation on the order keys.
  always_comb begin
    ka_s  = order_key(a1_r);
    kb_s  = order_key(b1_r);
    nan_s = is_nan(a1_r) | is_nan(b1_r);
    case (op1_r)
      CMP_GTE: rel_s = (ka_s >= kb_s);
      CMP_GT:  rel_s = (ka_s >  kb_s);
      CMP_EQ:  rel_s = (ka_s == kb_s);
      CMP_LT:  rel_s = (ka_s <  kb_s);
      CMP_LTE: rel_s = (ka_s <= kb_s);
      default: rel_s = 1'b0;
    endcase
  end

  // Stage 2: register the result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_res_valid <= 1'b0;
      o_res       <= 1'b0;
      o_nan_err   <= 1'b0;
    end else begin
      o_res_valid <= v1_r;
      o_res       <= v1_r & rel_s & ~nan_s;
      o_nan_err   <= v1_r & nan_s;
    end
  end

endmodule

// File: rtl/fp32_argext_ctrl.sv
// Streaming arg-max/arg-min controller: consumes a vector of FP32 words and uses
// one shared fp32_cmp_core to track the running extreme and its index.
module fp32_argext_ctrl
  import fp32_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [IDX_W:0]   i_len,
  output logic             o_busy,
  input  logic             i_valid,
  input  logic [31:0]      i_data,
  output logic             o_ready,
  output logic             o_done,
  output logic [31:0]      o_val,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_nan_err,
  output logic             o_len_err
);

  localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(MAX_LEN);
  localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);

  argext_state_e    state_r, state_nxt_s;
  logic             mode_r, mode_nxt_s;
  logic [IDX_W:0]   len_r, len_nxt_s;
  logic [IDX_W:0]   count_r, count_nxt_s;
  logic [31:0]      best_r, best_nxt_s;
  logic [IDX_W-1:0] best_idx_r, best_idx_nxt_s;
  logic             best_valid_r, best_valid_nxt_s;
  logic [31:0]      hold_r, hold_nxt_s;
  logic [IDX_W-1:0] hold_idx_r, hold_idx_nxt_s;
  logic             nan_err_r, nan_err_nxt_s;
  logic             len_err_r, len_err_nxt_s;
  logic [31:0]      val_r, val_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic             ready_r, busy_r, done_r;
  logic             hs_s, last_s, load_res_s, clr_res_s;
  logic             cmp_valid_s;
  cmp_op_e          cmp_op_s;
  logic             cmp_res_valid_s, cmp_res_s, cmp_nan_s;

  fp32_cmp_core u_cmp (
    .clk         (clk),
    .rstn        (rstn),
    .i_valid     (cmp_valid_s),
    .i_a         (i_data),
    .i_b         (best_r),
    .i_op        (cmp_op_s),
    .o_res_valid (cmp_res_valid_s),
    .o_res       (cmp_res_s),
    .o_nan_err   (cmp_nan_s)
  );

  // Next-state and datapath control.
  always_comb begin
    state_nxt_s      = state_r;
    mode_nxt_s       = mode_r;
    len_nxt_s        = len_r;
    count_nxt_s      = count_r;
    best_nxt_s       = best_r;
    best_idx_nxt_s   = best_idx_r;
    best_valid_nxt_s = best_valid_r;
    hold_nxt_s       = hold_r;
    hold_idx_nxt_s   = hold_idx_r;
    nan_err_nxt_s    = nan_err_r;
    len_err_nxt_s    = len_err_r;
    load_res_s       = 1'b0;
    clr_res_s        = 1'b0;
    cmp_valid_s      = 1'b0;
    cmp_op_s         = mode_r ? CMP_LT : CMP_GT;
    hs_s             = i_valid & ready_r;
    last_s           = ((count_r + ONE) == len_r);

    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          clr_res_s     = 1'b1;
          nan_err_nxt_s = 1'b0;
          if ((i_len != '0) && (i_len <= LEN_MAX)) begin
            mode_nxt_s       = i_mode;
            len_nxt_s        = i_len;
            count_nxt_s      = '0;
            best_valid_nxt_s = 1'b0;
            len_err_nxt_s    = 1'b0;
            state_nxt_s      = ST_RUN;
          end else begin
            len_err_nxt_s = 1'b1;
            state_nxt_s   = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (hs_s) begin
          count_nxt_s = count_r + ONE;
          if (is_nan(i_data)) begin
            nan_err_nxt_s = 1'b1;
            state_nxt_s   = last_s ? ST_DONE : ST_RUN;
            load_res_s    = last_s;
          end else if (!best_valid_r) begin
            best_nxt_s       = i_data;
            best_idx_nxt_s   = count_r[IDX_W-1:0];
            best_valid_nxt_s = 1'b1;
            state_nxt_s      = last_s ? ST_DONE : ST_RUN;
            load_res_s       = last_s;
          end else begin
            cmp_valid_s    = 1'b1;
            hold_nxt_s     = i_data;
            hold_idx_nxt_s = count_r[IDX_W-1:0];
            state_nxt_s    = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end

      // The comparator has fixed latency, but the update still keys off its valid.
      ST_WAIT: begin
        if (cmp_res_valid_s) begin
          if (cmp_res_s) begin
            best_nxt_s     = hold_r;
            best_idx_nxt_s = hold_idx_r;
          end else begin
            best_nxt_s     = best_r;
            best_idx_nxt_s = best_idx_r;
          end
          nan_err_nxt_s = nan_err_r | cmp_nan_s;
          if (count_r == len_r) begin
            state_nxt_s = ST_DONE;
            load_res_s  = 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end

      ST_DONE: state_nxt_s = ST_IDLE;

      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Result registers: cleared on an accepted start, loaded on the way into DONE.
  always_comb begin
    val_nxt_s = val_r;
    idx_nxt_s = idx_r;
    if (clr_res_s) begin
      val_nxt_s = 32'd0;
      idx_nxt_s = '0;
    end else if (load_res_s) begin
      if (best_valid_nxt_s) begin
        val_nxt_s = best_nxt_s;
        idx_nxt_s = best_idx_nxt_s;
      end else begin
        val_nxt_s = FP_QNAN;
        idx_nxt_s = '0;
      end
    end else begin
      val_nxt_s = val_r;
      idx_nxt_s = idx_r;
    end
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      mode_r       <= 1'b0;
      len_r        <= '0;
      count_r      <= '0;
      best_r       <= 32'd0;
      best_idx_r   <= '0;
      best_valid_r <= 1'b0;
      hold_r       <= 32'd0;
      hold_idx_r   <= '0;
      nan_err_r    <= 1'b0;
      len_err_r    <= 1'b0;
      val_r        <= 32'd0;
      idx_r        <= '0;
      ready_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      mode_r       <= mode_nxt_s;
      len_r        <= len_nxt_s;
      count_r      <= count_nxt_s;
      best_r       <= best_nxt_s;
      best_idx_r   <= best_idx_nxt_s;
      best_valid_r <= best_valid_nxt_s;
      hold_r       <= hold_nxt_s;
      hold_idx_r   <= hold_idx_nxt_s;
      nan_err_r    <= nan_err_nxt_s;
      len_err_r    <= len_err_nxt_s;
      val_r        <= val_nxt_s;
      idx_r        <= idx_nxt_s;
      ready_r      <= (state_nxt_s == ST_RUN);
      busy_r       <= (state_nxt_s != ST_IDLE);
      done_r       <= (state_nxt_s == ST_DONE);
    end
  end

  assign o_ready   = ready_r;
  assign o_busy    = busy_r;
  assign o_done    = done_r;
  assign o_val     = val_r;
  assign o_idx     = idx_r;
  assign o_nan_err = nan_err_r;
  assign o_len_err = len_err_r;

endmodule

// File: tb/tb_fp32_argext_ctrl.sv
// Self-checking bench for fp32_argext_ctrl: directed test-plan cases, a
// mid-WAIT reset, then randomized vectors against a sign-magnitude ordering model.
module tb_fp32_argext_ctrl;

  localparam int MAX_LEN = 256;
  localparam int IDX_W   = 8;

  logic             clk;
  logic             rstn;
  logic             i_start;
  logic             i_mode;
  logic [IDX_W:0]   i_len;
  logic             o_busy;
  logic             i_valid;
  logic [31:0]      i_data;
  logic             o_ready;
  logic             o_done;
  logic [31:0]      o_val;
  logic [IDX_W-1:0] o_idx;
  logic             o_nan_err;
  logic             o_len_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] vec_mem [0:MAX_LEN-1];

  logic [31:0] r_val;
  logic [31:0] r_idx;
  logic        r_nan, r_len_err, r_timeout, r_busy_after;
  int          r_hs2done, r_st2done, r_consumed;

  logic [31:0] m_val;
  logic [31:0] m_idx;
  logic        m_nan;

  fp32_argext_ctrl #(.MAX_LEN(MAX_LEN), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_start   (i_start),
    .i_mode    (i_mode),
    .i_len     (i_len),
    .o_busy    (o_busy),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .o_done    (o_done),
    .o_val     (o_val),
    .o_idx     (o_idx),
    .o_nan_err (o_nan_err),
    .o_len_err (o_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference ordering: is a strictly above b in sign-magnitude order?
  function automatic logic fp_above(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return b[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic logic ref_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  task automatic model_ref(input logic mode, input int len);
    logic have;
    have  = 1'b0;
    m_nan = 1'b0;
    m_val = 32'h7FC0_0000;
    m_idx = 32'd0;
    for (int i = 0; i < len; i++) begin
      if (ref_nan(vec_mem[i])) begin
        m_nan = 1'b1;
      end else if (!have || (mode ? fp_above(m_val, vec_mem[i]) : fp_above(vec_mem[i], m_val))) begin
        have  = 1'b1;
        m_val = vec_mem[i];
        m_idx = i;
      end
    end
  endtask

  task automatic run_vec(input logic mode, input int len, input int gap_pct, input bit poke);
    int  k, cyc, first_hs;
    bit  seen, hs;
    i_mode  = mode;
    i_len   = len[IDX_W:0];
    i_start = 1'b1;
    i_valid = 1'b0;
    step();
    i_start  = 1'b0;
    cyc      = 1;
    k        = 0;
    first_hs = -1;
    seen     = 1'b0;
    for (int b = 0; b < 3000; b++) begin
      if (o_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (k < len && k < MAX_LEN && $urandom_range(99) >= gap_pct) begin
        i_valid = 1'b1;
        i_data  = vec_mem[k];
      end else begin
        i_valid = 1'b0;
        i_data  = $urandom;
      end
      if (poke && $urandom_range(3) == 0) begin
        i_start = 1'b1;
        i_len   = '0;
        i_mode  = ~mode;
      end else begin
        i_start = 1'b0;
      end
      hs = i_valid && (o_ready === 1'b1);
      if (hs && first_hs < 0) first_hs = cyc;
      step();
      cyc++;
      if (hs) k++;
    end
    i_valid      = 1'b0;
    i_start      = 1'b0;
    r_timeout    = ~seen;
    r_val        = o_val;
    r_idx        = {24'd0, o_idx};
    r_nan        = o_nan_err;
    r_len_err    = o_len_err;
    r_hs2done    = cyc - first_hs;
    r_st2done    = cyc;
    r_consumed   = k;
    step();
    r_busy_after = o_busy;
  endtask

  task automatic expect_run(input string t, input logic [31:0] ev, input logic [31:0] ei,
                            input logic en, input logic el, input int ncons);
    check_eq($sformatf("%s_timeout", t), {31'd0, r_timeout}, 32'd0);
    check_eq($sformatf("%s_val", t), r_val, ev);
    check_eq($sformatf("%s_idx", t), r_idx, ei);
    check_eq($sformatf("%s_nan", t), {31'd0, r_nan}, {31'd0, en});
    check_eq($sformatf("%s_lenerr", t), {31'd0, r_len_err}, {31'd0, el});
    check_eq($sformatf("%s_consumed", t), r_consumed, ncons);
    check_eq($sformatf("%s_busy_after", t), {31'd0, r_busy_after}, 32'd0);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] x;
    case ($urandom_range(9))
      0: x = 32'h0000_0000;
      1: x = 32'h8000_0000;
      2: x = 32'h7F80_0000;
      3: x = 32'hFF80_0000;
      4: x = {1'($urandom_range(1)), 8'hFF, 23'($urandom_range(1, 23'h7F_FFFF))};
      5: x = {1'($urandom_range(1)), 8'h00, 23'($urandom)};
      6, 7: begin
        case ($urandom_range(3))
          0: x = 32'h3F80_0000;
          1: x = 32'hBF80_0000;
          2: x = 32'h4000_0000;
          default: x = 32'h0000_0001;
        endcase
      end
      default: x = $urandom;
    endcase
    return x;
  endfunction

  initial begin
    rstn    = 1'b0;
    i_start = 1'b0;
    i_mode  = 1'b0;
    i_len   = '0;
    i_valid = 1'b0;
    i_data  = 32'd0;
    step();
    step();
    check_eq("reset_flags", {27'd0, o_ready, o_busy, o_done, o_nan_err, o_len_err}, 32'd0);
    check_eq("reset_val", o_val, 32'd0);
    check_eq("reset_idx", {24'd0, o_idx}, 32'd0);
    rstn = 1'b1;
    step();
    check_eq("idle_ready_busy", {30'd0, o_ready, o_busy}, 32'd0);

    // Max over {1.0, 3.0, -2.0, 3.0}: tie keeps first 3.0, done 10 cycles after first handshake.
    vec_mem[0] = 32'h3F80_0000; vec_mem[1] = 32'h4040_0000;
    vec_mem[2] = 32'hC000_0000; vec_mem[3] = 32'h4040_0000;
    run_vec(1'b0, 4, 0, 1'b0);
    expect_run("max4", 32'h4040_0000, 32'd1, 1'b0, 1'b0, 4);
    check_eq("max4_latency", r_hs2done, 32'd10);

    vec_mem[0] = 32'h0000_0000; vec_mem[1] = 32'h8000_0000; vec_mem[2] = 32'h7F80_0000;
    run_vec(1'b1, 3, 0, 1'b0);
    expect_run("min_zero", 32'h8000_0000, 32'd1, 1'b0, 1'b0, 3);

    vec_mem[0] = 32'h7FC0_0001; vec_mem[1] = 32'h4000_0000; vec_mem[2] = 32'h3F80_0000;
    run_vec(1'b0, 3, 0, 1'b0);
    expect_run("nan_first", 32'h4000_0000, 32'd1, 1'b1, 1'b0, 3);

    vec_mem[0] = 32'h7FC0_0000; vec_mem[1] = 32'hFF80_0001;
    run_vec(1'b0, 2, 0, 1'b0);
    expect_run("all_nan", 32'h7FC0_0000, 32'd0, 1'b1, 1'b0, 2);

    run_vec(1'b0, 0, 0, 1'b0);
    expect_run("len0", 32'd0, 32'd0, 1'b0, 1'b1, 0);
    check_eq("len0_latency", r_st2done, 32'd1);

    run_vec(1'b1, MAX_LEN + 1, 0, 1'b0);
    expect_run("len_over", 32'd0, 32'd0, 1'b0, 1'b1, 0);
    check_eq("len_over_latency", r_st2done, 32'd1);

    vec_mem[0] = 32'hC000_0000;
    run_vec(1'b0, 1, 0, 1'b0);
    expect_run("len1", 32'hC000_0000, 32'd0, 1'b0, 1'b0, 1);
    check_eq("len1_latency", r_hs2done, 32'd1);

    // Reset while the controller waits on the comparator.
    i_mode = 1'b0; i_len = 9'd3; i_start = 1'b1;
    step();
    i_start = 1'b0; i_valid = 1'b1; i_data = 32'h3F80_0000;
    step();
    i_data = 32'h4000_0000;
    step();
    check_eq("wait_ready_low", {30'd0, o_ready, o_busy}, 32'd1);
    rstn = 1'b0;
    #1;
    check_eq("midrst_flags", {27'd0, o_ready, o_busy, o_done, o_nan_err, o_len_err}, 32'd0);
    check_eq("midrst_val", o_val, 32'd0);
    i_valid = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
    vec_mem[0] = 32'h40A0_0000; vec_mem[1] = 32'h40E0_0000;
    run_vec(1'b0, 2, 0, 1'b0);
    expect_run("post_rst", 32'h40E0_0000, 32'd1, 1'b0, 1'b0, 2);

    // Randomized vectors with valid gaps and ignored start pulses.
    for (int r = 0; r < 40; r++) begin
      int len;
      logic mode;
      len  = $urandom_range(1, 16);
      mode = 1'($urandom_range(1));
      for (int i = 0; i < len; i++) vec_mem[i] = rand_fp();
      model_ref(mode, len);
      run_vec(mode, len, $urandom_range(0, 70), 1'($urandom_range(1)));
      expect_run($sformatf("rnd%0d", r), m_val, m_idx, m_nan, 1'b0, len);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
